apb_arbiter_master: RTL and testbench

APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

---
 rtl/apb_arbiter_master.sv | 162 ++++++++++++++++
 tb/tb_apb_arbiter_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter_master.sv
// Two-requester APB master: round-robin arbitration on ties, back-to-back
// transfers, and a bounded wait-state counter that aborts stalled accesses.
module apb_arbiter_master #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic                    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [1:0]              resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;

  logic any_req;
  logic win;
  logic do_grant;

  assign any_req = |req_valid;
  // On a tie the requester that did not win last time goes next.
  assign win     = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    resp_valid_d = 2'b00;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    req_ready    = 2'b00;
    do_grant     = 1'b0;

    case (state_q)
      IDLE: begin
        do_grant = any_req;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          resp_valid_d = gnt_q ? 2'b10 : 2'b01;
          resp_err_d   = PSLVERR;
          resp_rdata_d = pwrite_q ? '0 : PRDATA;
          do_grant     = any_req;
          state_d      = IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Slave stalled too long: abort with an error response.
          resp_valid_d = gnt_q ? 2'b10 : 2'b01;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          state_d      = IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant && !PRESET) begin
      req_ready    = win ? 2'b10 : 2'b01;
      gnt_d        = win;
      last_grant_d = win;
      paddr_d      = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      pwdata_d     = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      pwrite_d     = win ? req_write[1] : req_write[0];
      pstrb_d      = pwrite_d ? '1 : '0;
      state_d      = SETUP;
      psel_d       = 1'b1;
      penable_d    = 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Randomized scoreboard bench for apb_arbiter_master: a transaction-level
// model predicts grants, APB phase timeline and responses per cycle.
module tb_apb_arbiter_master;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;
  localparam int unsigned SW = DW / 8;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b1;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_write = 2'b00;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      req_ready;
  logic [1:0]      resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic [AW-1:0]   PADDR;
  logic            PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [DW-1:0]   PWDATA;
  logic [SW-1:0]   PSTRB;
  logic [DW-1:0]   PRDATA = '0;
  logic            PREADY = 1'b0;
  logic            PSLVERR = 1'b0;

  apb_arbiter_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int   cyc = 0;
  logic rst_prev = 1'b1;
  always @(posedge PCLK) begin
    cyc      <= cyc + 1;
    rst_prev <= PRESET;
  end

  typedef struct { int cyc; logic [1:0] v; } ready_t;
  typedef struct { int cyc; logic [1:0] v; logic [DW-1:0] rdata; logic err; } resp_t;
  typedef struct { logic setup; logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; } apb_t;
  typedef struct { int w; logic to; logic [DW-1:0] rdata; logic err; } plan_t;

  ready_t ready_q[$];
  resp_t  resp_q[$];
  apb_t   exp_apb[int];
  plan_t  plan_q[$];
  plan_t  dir_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Requester and model state
  logic [1:0]    pend = 2'b00;
  logic [1:0]    p_wr = 2'b00;
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  int            rate = 0;
  logic          rst = 1'b1;
  logic          last_g = 1'b1;
  int            free_at = 0;

  task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, c, act, exp);
    end
  endtask

  task automatic step();
    logic   g;
    plan_t  pl;
    int     r;
    int     n_acc;
    int     kill[$];
    resp_t  keep[$];
    @(negedge PCLK);
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < rate) begin
        pend[i]    = 1'b1;
        p_wr[i]    = 1'($urandom);
        p_addr[i]  = AW'($urandom);
        p_wdata[i] = DW'($urandom);
      end
    end
    PRESET    = rst;
    req_valid = pend;
    req_write = p_wr;
    req_addr  = {p_addr[1], p_addr[0]};
    req_wdata = {p_wdata[1], p_wdata[0]};
    if (rst) begin
      // Any transfer in flight is dropped: forget its future phases and response.
      foreach (exp_apb[k]) if (k > cyc) kill.push_back(k);
      foreach (kill[j]) exp_apb.delete(kill[j]);
      foreach (resp_q[j]) if (resp_q[j].cyc <= cyc) keep.push_back(resp_q[j]);
      resp_q = keep;
      plan_q.delete();
      last_g  = 1'b1;
      free_at = 0;
      ready_q.push_back('{cyc, 2'b00});
    end else if (cyc >= free_at && pend != 2'b00) begin
      g = (pend == 2'b11) ? !last_g : pend[1];
      if (dir_q.size() != 0) pl = dir_q.pop_front();
      else begin
        r = $urandom_range(0, 19);
        pl.to = 1'b0;
        pl.w  = 0;
        if (r < 10)      pl.w = 0;
        else if (r < 16) pl.w = $urandom_range(1, 3);
        else if (r < 18) pl.w = int'(TO) - 1;
        else if (r < 19) pl.to = 1'b1;
        else             pl.w = 4;
        pl.rdata = DW'($urandom);
        pl.err   = ($urandom_range(0, 3) == 0);
      end
      plan_q.push_back(pl);
      n_acc = pl.to ? int'(TO) : pl.w + 1;
      exp_apb[cyc + 1] = '{1'b1, p_addr[g], p_wr[g], p_wdata[g]};
      for (int k = 0; k < n_acc; k++) exp_apb[cyc + 2 + k] = '{1'b0, p_addr[g], p_wr[g], p_wdata[g]};
      resp_q.push_back('{pl.to ? cyc + 2 + int'(TO) : cyc + 3 + pl.w,
                         g ? 2'b10 : 2'b01,
                         (pl.to || p_wr[g]) ? DW'(0) : pl.rdata,
                         pl.to ? 1'b1 : pl.err});
      free_at = pl.to ? cyc + 2 + int'(TO) : cyc + 2 + pl.w;
      last_g  = g;
      pend[g] = 1'b0;
      ready_q.push_back('{cyc, g ? 2'b10 : 2'b01});
    end else begin
      ready_q.push_back('{cyc, 2'b00});
    end
  endtask

  // APB slave: follows the per-transfer plan chosen by the model.
  initial begin
    plan_t cur;
    int    left;
    cur  = '{0, 1'b1, DW'(0), 1'b0};
    left = 0;
    forever begin
      @(negedge PCLK);
      if (PSEL === 1'b1 && PENABLE === 1'b0) begin
        if (plan_q.size() != 0) cur = plan_q.pop_front();
        else cur = '{0, 1'b1, DW'(0), 1'b0};
        left    = cur.w;
        PREADY  = 1'($urandom);
        PRDATA  = DW'($urandom);
        PSLVERR = 1'($urandom);
      end else if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        if (!cur.to && left == 0) begin
          PREADY  = 1'b1;
          PRDATA  = cur.rdata;
          PSLVERR = cur.err;
        end else begin
          PREADY  = 1'b0;
          left--;
          PRDATA  = DW'($urandom);
          PSLVERR = 1'($urandom);
        end
      end else begin
        PREADY  = 1'($urandom);
        PRDATA  = DW'($urandom);
        PSLVERR = 1'($urandom);
      end
    end
  end

  // Monitor: pops per-cycle expectations and compares against the DUT.
  initial begin
    ready_t        er;
    resp_t         rs;
    apb_t          ea;
    int            c;
    logic [DW-1:0] last_rd;
    logic          last_err;
    logic [SW-1:0] es;
    last_rd  = '0;
    last_err = 1'b0;
    forever begin
      @(negedge PCLK);
      #2;
      if (ready_q.size() == 0) continue;
      er = ready_q.pop_front();
      c  = er.cyc;
      chk("req_ready", c, 64'(req_ready), 64'(er.v));
      if (exp_apb.exists(c)) begin
        ea = exp_apb[c];
        es = ea.wr ? '1 : '0;
        chk("psel", c, 64'(PSEL), 64'(1'b1));
        chk("penable", c, 64'(PENABLE), 64'(!ea.setup));
        chk("paddr", c, 64'(PADDR), 64'(ea.addr));
        chk("pwrite", c, 64'(PWRITE), 64'(ea.wr));
        chk("pwdata", c, 64'(PWDATA), 64'(ea.wdata));
        chk("pstrb", c, 64'(PSTRB), 64'(es));
        exp_apb.delete(c);
      end else begin
        chk("psel_idle", c, 64'({PSEL, PENABLE}), 64'(2'b00));
      end
      if (rst_prev) begin
        last_rd  = '0;
        last_err = 1'b0;
        chk("rst_paddr", c, 64'(PADDR), 64'(0));
        chk("rst_pwrite", c, 64'(PWRITE), 64'(0));
        chk("rst_pwdata", c, 64'(PWDATA), 64'(0));
        chk("rst_pstrb", c, 64'(PSTRB), 64'(0));
      end
      if (resp_q.size() != 0 && resp_q[0].cyc == c) begin
        rs = resp_q.pop_front();
        chk("resp_valid", c, 64'(resp_valid), 64'(rs.v));
        chk("resp_rdata", c, 64'(resp_rdata), 64'(rs.rdata));
        chk("resp_err", c, 64'(resp_err), 64'(rs.err));
        last_rd  = rs.rdata;
        last_err = rs.err;
      end else begin
        chk("resp_quiet", c, 64'(resp_valid), 64'(2'b00));
        chk("resp_rdata_hold", c, 64'(resp_rdata), 64'(last_rd));
        chk("resp_err_hold", c, 64'(resp_err), 64'(last_err));
      end
    end
  end

  initial begin
    int k;
    p_addr[0]  = '0; p_addr[1]  = '0;
    p_wdata[0] = '0; p_wdata[1] = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Single zero-wait read from requester 0
    pend[0] = 1'b1; p_wr[0] = 1'b0; p_addr[0] = AW'(14'h0040); p_wdata[0] = '0;
    dir_q.push_back('{0, 1'b0, 32'hDEADBEEF, 1'b0});
    repeat (6) step();

    // Write with three wait states ending in a slave error
    pend[1] = 1'b1; p_wr[1] = 1'b1; p_addr[1] = AW'(14'h0100); p_wdata[1] = 32'h12345678;
    dir_q.push_back('{3, 1'b0, 32'hCAFEF00D, 1'b1});
    repeat (9) step();

    // Slave never ready: abort after TIMEOUT access cycles
    pend[0] = 1'b1; p_wr[0] = 1'b0; p_addr[0] = AW'(14'h0abc);
    dir_q.push_back('{0, 1'b1, 32'h0, 1'b0});
    repeat (TO + 5) step();

    // Continuous tie: grants alternate, transfers back-to-back
    rate = 100;
    repeat (4) dir_q.push_back('{0, 1'b0, DW'($urandom), 1'b0});
    repeat (20) step();

    // Reset during a wait state, then a tie right after release
    rate = 0;
    repeat (TO + 6) step();
    pend = 2'b11;
    p_wr[0] = 1'b1; p_addr[0] = AW'(14'h0123); p_wdata[0] = 32'h0badf00d;
    p_wr[1] = 1'b0; p_addr[1] = AW'(14'h0321); p_wdata[1] = 32'h11110000;
    dir_q.push_back('{0, 1'b1, 32'h0, 1'b0});
    repeat (5) step();
    rst = 1'b1; rate = 100;
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();

    // Randomized traffic
    rate = 35;
    repeat (1500) step();

    rate = 0;
    k = 0;
    while (k < 200 && (resp_q.size() != 0 || pend != 2'b00)) begin
      step();
      k++;
    end
    repeat (3) step();
    if (resp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending_responses=%0d required=0", resp_q.size());
    end
    #5;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
